sync_fifo_param: RTL and testbench

- Parametrised single-clock synchronous FIFO; next generation of the team's fixed 16x8 FIFO.
- Configurable data width and depth.
- Correct simultaneous read/write handling and an occupancy count output.
- Programmable almost-full/almost-empty flags and overflow/underflow error pulses.
- Used as the general-purpose buffer between producer/consumer blocks in one clock domain.

---
 rtl/sync_fifo_param_if.sv | 30 +++
 rtl/sync_fifo_param.sv | 91 +++++++++
 tb/tb_sync_fifo_param.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// Bundles the producer/consumer-facing signals of sync_fifo_param.
// master drives requests and write data; slave is the FIFO side.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);

  logic              we;
  logic              re;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [AW:0]       count;
  logic              overflow;
  logic              underflow;

  modport master (
    output we, re, data_in,
    input  data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  we, re, data_in,
    output data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and registered overflow/underflow pulses.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input logic               clk,
  input logic               rst,
  sync_fifo_param_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_CNT    = (AW+1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic empty, full, wr_acc, rd_acc;

  // Flags decode the registered count, so they carry no extra latency.
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_CNT);

  always_comb begin
    wr_acc      = bus.we & ~full;
    rd_acc      = bus.re & ~empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    overflow_d  = bus.we & full;
    underflow_d = bus.re & empty;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      data_out_d = mem_q[rd_ptr_q];
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left uncleared by reset; the pointers hide stale words.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (count_q <= AE_CNT);
  assign bus.almost_full  = (count_q >= AF_CNT);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param at default parameters:
// fill/drain, overflow/underflow, streaming across wrap, and mid-run reset.
module tb_sync_fifo_param;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) bus ();

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after an edge; outputs are sampled there too.
  task automatic applyStimulus(input logic r, input logic w, input logic rd, input logic [7:0] d);
    rst         = r;
    bus.we      = w;
    bus.re      = rd;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkFlags(input string tag, input int cnt, input logic ov, input logic un);
    checkOutput({tag, " count"}, 32'(bus.count), 32'(cnt));
    checkOutput({tag, " empty"}, 32'(bus.empty), 32'(cnt == 0));
    checkOutput({tag, " full"}, 32'(bus.full), 32'(cnt == 16));
    checkOutput({tag, " almost_empty"}, 32'(bus.almost_empty), 32'(cnt <= 2));
    checkOutput({tag, " almost_full"}, 32'(bus.almost_full), 32'(cnt >= 14));
    checkOutput({tag, " overflow"}, 32'(bus.overflow), 32'(ov));
    checkOutput({tag, " underflow"}, 32'(bus.underflow), 32'(un));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus.we       = 1'b0;
    bus.re       = 1'b0;
    bus.data_in  = 8'h00;

    // Reset then idle
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkFlags("reset", 0, 1'b0, 1'b0);
    checkOutput("reset data_out", 32'(bus.data_out), 32'h00);

    // Fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(i));
      checkFlags("fill", i, 1'b0, 1'b0);
    end

    // Write to full FIFO is rejected
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hAA);
    checkFlags("overflow", 16, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkFlags("overflow clears", 16, 1'b0, 1'b0);

    // Drain in order
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput("drain data_out", 32'(bus.data_out), 32'(i));
      checkFlags("drain", 16 - i, 1'b0, 1'b0);
    end

    // Read from empty FIFO is rejected, data_out holds
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkFlags("underflow", 0, 1'b0, 1'b1);
    checkOutput("underflow data_out hold", 32'(bus.data_out), 32'h10);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkFlags("underflow clears", 0, 1'b0, 1'b0);

    // Stream at count=5 across pointer wrap
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
    end
    checkFlags("prefill5", 5, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 8'(8'h25 + k));
      checkOutput("stream data_out", 32'(bus.data_out), 32'(8'h20 + k));
      checkFlags("stream", 5, 1'b0, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput("stream tail", 32'(bus.data_out), 32'(8'h34 + i));
    end
    checkFlags("stream drained", 0, 1'b0, 1'b0);

    // Simultaneous we/re on a full FIFO: read only
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    end
    checkFlags("refill", 16, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h55);
    checkFlags("full we&re", 15, 1'b1, 1'b0);
    checkOutput("full we&re data_out", 32'(bus.data_out), 32'h40);
    for (int i = 1; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput("full drain", 32'(bus.data_out), 32'(8'h40 + i));
    end
    checkFlags("full drained", 0, 1'b0, 1'b0);

    // Simultaneous we/re on an empty FIFO: write only, no bypass
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h77);
    checkFlags("empty we&re", 1, 1'b0, 1'b1);
    checkOutput("empty we&re no bypass", 32'(bus.data_out), 32'h4F);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("empty we&re readback", 32'(bus.data_out), 32'h77);
    checkFlags("empty we&re drained", 0, 1'b0, 1'b0);

    // Reset mid-operation with we asserted
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
    end
    checkFlags("fill9", 9, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h99);
    checkFlags("mid reset", 0, 1'b0, 1'b0);
    checkOutput("mid reset data_out", 32'(bus.data_out), 32'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C);
    checkFlags("post reset write", 1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("post reset read", 32'(bus.data_out), 32'h3C);
    checkFlags("post reset drained", 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkFlags("post reset underflow", 0, 1'b0, 1'b1);
    checkOutput("post reset hold", 32'(bus.data_out), 32'h3C);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
